// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM-stage slot inputs, mul/div result handshake and
// register-file write port, grouped so the stage drops in as one bundle.
interface wb_stage_if;
  logic        in_valid;
  logic        in_regwrite;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_mem_rdata;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;

  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_ready;

  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        regwrite;

  modport master (
    output in_valid, in_regwrite, in_rd, in_wb_sel, in_alu_result,
           in_pc_plus4, in_mem_rdata, in_funct3, in_addr_lo,
           md_valid, md_rd, md_result,
    input  md_ready, writereg, writedata, regwrite
  );

  modport slave (
    input  in_valid, in_regwrite, in_rd, in_wb_sel, in_alu_result,
           in_pc_plus4, in_mem_rdata, in_funct3, in_addr_lo,
           md_valid, md_rd, md_result,
    output md_ready, writereg, writedata, regwrite
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: one registered slot, load extraction, and a single
// register-file write port shared between the pipeline and a mul/div unit.
module wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  wb_stage_if.slave        bus,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] retire_count
);

  logic             wb_valid_q;
  logic             wb_regwrite_q;
  logic [4:0]       wb_rd_q;
  logic [1:0]       wb_sel_q;
  logic [31:0]      wb_alu_q;
  logic [31:0]      wb_pc4_q;
  logic [31:0]      wb_rdata_q;
  logic [2:0]       wb_funct3_q;
  logic [1:0]       wb_addr_lo_q;
  logic [CNT_W-1:0] retire_q;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] pipe_data;
  logic        pipe_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_sel_q      <= '0;
      wb_alu_q      <= '0;
      wb_pc4_q      <= '0;
      wb_rdata_q    <= '0;
      wb_funct3_q   <= '0;
      wb_addr_lo_q  <= '0;
      retire_q      <= '0;
    end else if (!stall) begin
      // Retirement counts the instruction leaving the slot, so flush of the
      // incoming capture never cancels it.
      if (wb_valid_q) retire_q <= retire_q + CNT_W'(1);
      wb_valid_q    <= bus.in_valid & ~flush;
      wb_regwrite_q <= bus.in_regwrite;
      wb_rd_q       <= bus.in_rd;
      wb_sel_q      <= bus.in_wb_sel;
      wb_alu_q      <= bus.in_alu_result;
      wb_pc4_q      <= bus.in_pc_plus4;
      wb_rdata_q    <= bus.in_mem_rdata;
      wb_funct3_q   <= bus.in_funct3;
      wb_addr_lo_q  <= bus.in_addr_lo;
    end
  end

  always_comb begin
    ld_byte = wb_rdata_q[7:0];
    case (wb_addr_lo_q)
      2'd1:    ld_byte = wb_rdata_q[15:8];
      2'd2:    ld_byte = wb_rdata_q[23:16];
      2'd3:    ld_byte = wb_rdata_q[31:24];
      default: ld_byte = wb_rdata_q[7:0];
    endcase
    ld_half = wb_addr_lo_q[1] ? wb_rdata_q[31:16] : wb_rdata_q[15:0];

    case (wb_funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = wb_rdata_q;
    endcase

    case (wb_sel_q)
      2'b01:   pipe_data = ld_data;
      2'b10:   pipe_data = wb_pc4_q;
      default: pipe_data = wb_alu_q;
    endcase
  end

  assign pipe_wr = wb_valid_q & wb_regwrite_q & (wb_rd_q != 5'd0);

  // Pipeline owns the write port when it writes; otherwise mul/div gets it,
  // and a result aimed at x0 is accepted but produces no write.
  always_comb begin
    bus.md_ready  = 1'b0;
    bus.writereg  = '0;
    bus.writedata = '0;
    bus.regwrite  = 1'b0;
    if (pipe_wr) begin
      bus.writereg  = wb_rd_q;
      bus.writedata = pipe_data;
      bus.regwrite  = 1'b1;
    end else begin
      bus.md_ready = 1'b1;
      if (bus.md_valid && (bus.md_rd != 5'd0)) begin
        bus.writereg  = bus.md_rd;
        bus.writedata = bus.md_result;
        bus.regwrite  = 1'b1;
      end
    end
  end

  assign load_misaligned = wb_valid_q & (wb_sel_q == 2'b01) &
                           (((wb_funct3_q[1:0] == 2'b01) & wb_addr_lo_q[0]) |
                            ((wb_funct3_q == 3'b010) & (wb_addr_lo_q != 2'b00)));

  assign retire_count = retire_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: CNT_W, default 32, width of retire counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 stall  input  1  hold WB slot, do not capture.
REQ-005 flush  input  1  capture a bubble instead of MEM-stage inputs.
REQ-006 in_valid  input  1  MEM-stage instruction valid.
REQ-007 in_regwrite  input  1  instruction writes rd.
REQ-008 in_rd  input  5  destination register.
REQ-009 in_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 ALU.
REQ-010 in_alu_result  input  32  ALU result.
REQ-011 in_pc_plus4  input  32  link value.
REQ-012 in_mem_rdata  input  32  raw data-memory word.
REQ-013 in_funct3  input  3  load type.
REQ-014 in_addr_lo  input  2  load address bits [1:0].
REQ-015 md_valid  input  1  multi-cycle mul/div result offered.
REQ-016 md_rd  input  5  mul/div destination.
REQ-017 md_result  input  32  mul/div result.
REQ-018 md_ready  output  1  mul/div result accepted this cycle.
REQ-019 writereg  output  5  register-file write address.
REQ-020 writedata  output  32  register-file write data.
REQ-021 regwrite  output  1  register-file write enable.
REQ-022 load_misaligned  output  1  WB slot holds a misaligned load.
REQ-023 retire_count  output  CNT_W  retired pipeline instructions.

Function
REQ-024 WB slot registers all in_* fields plus wb_valid; on edge with !stall: wb_valid <= in_valid & !flush, other fields <= inputs.
REQ-025 stall=1 holds every slot field; stall has priority over flush.
REQ-026 Load extraction on registered fields: 000 LB sign-extended byte at addr_lo; 100 LBU zero-extended byte; 001 LH / 101 LHU halfword selected by addr_lo[1], sign/zero-extended; 010 and all other codes full word.
REQ-027 Pipeline data: wb_sel 01 extracted load, 10 pc_plus4, 00/11 alu_result.
REQ-028 pipe_wr = wb_valid & wb_regwrite & (wb_rd != 0).
REQ-029 pipe_wr=1: writereg=wb_rd, writedata=pipeline data, regwrite=1, md_ready=0.
REQ-030 pipe_wr=0: md_ready=1; writereg=md_rd, writedata=md_result, regwrite=md_valid & (md_rd != 0).
REQ-031 Outputs of REQ-029/030 are combinational from slot and md_* inputs; zero-latency to the register file.
REQ-032 When no write occurs, writereg=0, writedata=0, regwrite=0.
REQ-033 md handshake: result transferred when md_valid & md_ready; md_valid with md_rd=0 is accepted and discarded.
REQ-034 Stalled slot with pipe_wr=1 re-asserts the same write each cycle (idempotent) and keeps md_ready=0.
REQ-035 load_misaligned = wb_valid & wb_sel==01 & ((funct3[1:0]==01 & addr_lo[0]) | (funct3==010 & addr_lo!=0)); data still extracted per REQ-026.
REQ-036 retire_count increments by 1 on each edge with !stall & wb_valid; wraps at 2^CNT_W-1 -> 0.
REQ-037 Flush affects only the incoming capture; instruction already in WB still writes and retires.

Reset
REQ-038 On rst edge: wb_valid=0, all slot fields=0, retire_count=0; rst overrides stall and flush.
REQ-039 After reset before any capture: regwrite=0 unless md_valid & md_rd!=0, md_ready=1, load_misaligned=0.

Verification
REQ-040 LB, addr_lo=11, rdata=0x80FF_0000, rd=5 -> writereg=5, writedata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-041 LH addr_lo=01 -> load_misaligned=1; LHU addr_lo=10, rdata=0x8001_1234 -> writedata=0x0000_8001.
REQ-042 Slot ALU write rd=3 with md_valid=1, md_rd=7 -> md_ready=0, writereg=3; next cycle bubble -> md_ready=1, writereg=7, writedata=md_result.
REQ-043 in_rd=0, in_regwrite=1 -> regwrite=0, retire_count still increments next non-stalled edge.
REQ-044 flush=1 with stall=0 -> next cycle wb_valid=0, no write; stall=1 & flush=1 -> slot unchanged, count frozen.
REQ-045 rst asserted mid-stream with valid slot -> next cycle regwrite=0, retire_count=0; CNT_W=4 after 16 retirements -> retire_count=0.
